// File: rtl/fetch_sched.sv
// rtl/fetch_sched.sv - instruction fetch PC scheduler with program-loader arbitration
module fetch_sched #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    input  logic        ld_req_i,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_data_i,
    input  logic        ld_last_i,
    output logic [31:0] imem_addr_o,
    output logic        imem_we_o,
    output logic [31:0] imem_wdata_o,
    output logic [31:0] pc_o,
    output logic        fetch_valid_o,
    output logic        ld_gnt_o,
    output logic        redirect_err_o,
    output logic [1:0]  state_o
);

    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        redirect_err_q, redirect_err_d;
    logic        redir_ok;
    logic        redir_bad;

    // A redirect is only honoured when the target is word aligned
    always_comb begin
        redir_ok  = redirect_i & (redirect_pc_i[1:0] == 2'b00);
        redir_bad = redirect_i & (redirect_pc_i[1:0] != 2'b00);
    end

    // State, PC and error-pulse registers; reset acts without a clock edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            pc_q           <= RESET_PC;
            redirect_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            redirect_err_q <= redirect_err_d;
        end
    end

    // Next state and next PC; LOAD ignores stall/halt, illegal encoding recovers to RUN
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        redirect_err_d = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                redirect_err_d = redir_bad;
                if (ld_req_i)    state_d = ST_LOAD;
                else if (halt_i) state_d = ST_HALT;
                else             state_d = ST_RUN;
                if (redir_ok)     pc_d = redirect_pc_i;
                else if (stall_i) pc_d = pc_q;
                else              pc_d = pc_q + 32'd4;
            end
            ST_LOAD: begin
                if (ld_req_i && ld_last_i) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_HALT: begin
                redirect_err_d = redir_bad;
                if (ld_req_i) begin
                    state_d = ST_LOAD;
                end else if (redir_ok) begin
                    state_d = ST_RUN;
                    pc_d    = redirect_pc_i;
                end
            end
            default: begin
                state_d = ST_RUN;
                pc_d    = RESET_PC;
            end
        endcase
    end

    // Outputs decoded from current state plus zero-latency input terms
    always_comb begin
        ld_gnt_o       = (state_q == ST_LOAD);
        imem_addr_o    = ld_gnt_o ? ld_addr_i : pc_q;
        imem_we_o      = ld_req_i & ld_gnt_o;
        imem_wdata_o   = ld_gnt_o ? ld_data_i : 32'h0;
        fetch_valid_o  = (state_q == ST_RUN) & ~stall_i & ~ld_req_i;
        pc_o           = pc_q;
        redirect_err_o = redirect_err_q;
        state_o        = state_q;
    end

endmodule

// File: tb/tb_fetch_sched.sv
// tb/tb_fetch_sched.sv - scoreboard testbench for fetch_sched
module tb_fetch_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_i, redirect_i, halt_i, ld_req_i, ld_last_i;
    logic [31:0] redirect_pc_i, ld_addr_i, ld_data_i;
    logic [31:0] imem_addr_o, imem_wdata_o, pc_o;
    logic        imem_we_o, fetch_valid_o, ld_gnt_o, redirect_err_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [1:0]  m_state;
    logic [31:0] m_pc;
    logic        m_err;

    fetch_sched #(.RESET_PC(32'h0000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall_i        (stall_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .halt_i         (halt_i),
        .ld_req_i       (ld_req_i),
        .ld_addr_i      (ld_addr_i),
        .ld_data_i      (ld_data_i),
        .ld_last_i      (ld_last_i),
        .imem_addr_o    (imem_addr_o),
        .imem_we_o      (imem_we_o),
        .imem_wdata_o   (imem_wdata_o),
        .pc_o           (pc_o),
        .fetch_valid_o  (fetch_valid_o),
        .ld_gnt_o       (ld_gnt_o),
        .redirect_err_o (redirect_err_o),
        .state_o        (state_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic hl,
                         input logic lr, input logic [31:0] la, input logic [31:0] ldat, input logic ll);
        stall_i = st; redirect_i = rd; redirect_pc_i = rpc; halt_i = hl;
        ld_req_i = lr; ld_addr_i = la; ld_data_i = ldat; ld_last_i = ll;
    endtask

    task automatic idle();
        drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    endtask

    // Check combinational outputs, predict next registered state, clock, compare.
    task automatic cycle();
        exp_t   e;
        exp_t   got;
        logic   in_load, in_run, in_halt, aligned;
        #1;
        in_run  = (m_state == 2'b00);
        in_load = (m_state == 2'b01);
        in_halt = (m_state == 2'b10);
        check("fetch_valid", {31'h0, fetch_valid_o}, {31'h0, in_run && !stall_i && !ld_req_i});
        check("ld_gnt", {31'h0, ld_gnt_o}, {31'h0, in_load});
        check("imem_we", {31'h0, imem_we_o}, {31'h0, in_load && ld_req_i});
        check("imem_addr", imem_addr_o, in_load ? ld_addr_i : m_pc);
        check("imem_wdata", imem_wdata_o, in_load ? ld_data_i : 32'h0);

        aligned = redirect_i && (redirect_pc_i[1:0] == 2'b00);
        e.st  = m_state;
        e.pc  = m_pc;
        e.err = (in_run || in_halt) && redirect_i && !aligned;
        if (in_run) begin
            e.st = ld_req_i ? 2'b01 : (halt_i ? 2'b10 : 2'b00);
            e.pc = aligned ? redirect_pc_i : (stall_i ? m_pc : m_pc + 32'd4);
        end else if (in_load) begin
            if (ld_req_i && ld_last_i) begin e.st = 2'b00; e.pc = 32'h0; end
        end else if (in_halt) begin
            if (ld_req_i) e.st = 2'b01;
            else if (aligned) begin e.st = 2'b00; e.pc = redirect_pc_i; end
        end
        sb_q.push_back(e);

        @(posedge clock);
        #1;
        got = sb_q.pop_front();
        check("state", {30'h0, state_o}, {30'h0, got.st});
        check("pc", pc_o, got.pc);
        check("redirect_err", {31'h0, redirect_err_o}, {31'h0, got.err});
        m_state = got.st;
        m_pc    = got.pc;
        m_err   = got.err;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        m_state = 2'b00; m_pc = 32'h0; m_err = 1'b0;
        #1;
        check("rst_state", {30'h0, state_o}, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_err", {31'h0, redirect_err_o}, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // Idle run from reset: 4, 8, 12, 16
        for (int i = 1; i <= 4; i++) begin
            idle(); cycle();
            check("idle_pc", pc_o, 32'(4 * i));
        end

        // Go to PC=8, stall twice, redirect to 0x100, then step
        drive(0, 1, 32'h8, 0, 0, 0, 0, 0); cycle(); check("redir8", pc_o, 32'h8);
        drive(1, 0, 32'h0, 0, 0, 0, 0, 0); cycle(); check("stall1", pc_o, 32'h8);
        drive(1, 0, 32'h0, 0, 0, 0, 0, 0); cycle(); check("stall2", pc_o, 32'h8);
        drive(1, 1, 32'h100, 0, 0, 0, 0, 0); cycle(); check("redir100", pc_o, 32'h100);
        idle(); cycle(); check("pc104", pc_o, 32'h104);

        // Misaligned redirect is ignored and pulses the error for one cycle
        drive(0, 1, 32'h102, 0, 0, 0, 0, 0); cycle();
        check("mis_pc", pc_o, 32'h108);
        check("mis_err", {31'h0, redirect_err_o}, 32'h1);
        idle(); cycle();
        check("mis_err_clr", {31'h0, redirect_err_o}, 32'h0);

        // Halt, freeze, misaligned redirect in HALT, then exit via redirect
        drive(0, 0, 32'h0, 1, 0, 0, 0, 0); cycle();
        check("halt_state", {30'h0, state_o}, 32'h2);
        idle(); cycle(); check("halt_frozen", pc_o, 32'h110);
        drive(0, 1, 32'h43, 0, 0, 0, 0, 0); cycle();
        check("halt_mis_err", {31'h0, redirect_err_o}, 32'h1);
        drive(0, 1, 32'h40, 0, 0, 0, 0, 0); cycle();
        check("halt_exit_pc", pc_o, 32'h40);
        check("halt_exit_st", {30'h0, state_o}, 32'h0);

        // Redirect together with halt: PC takes target, state goes HALT
        drive(0, 1, 32'h200, 1, 0, 0, 0, 0); cycle();
        check("redir_halt_pc", pc_o, 32'h200);
        drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0); cycle();

        // Wrap at top of address space
        idle(); cycle(); check("wrap", pc_o, 32'h0);
        for (int i = 0; i < 3; i++) begin idle(); cycle(); end

        // Three-beat load; halt/stall asserted in LOAD must be ignored
        drive(0, 0, 0, 0, 1, 32'h0, 32'hA0A0_0001, 0); cycle();
        check("ld_enter", {30'h0, state_o}, 32'h1);
        drive(1, 0, 0, 1, 1, 32'h0, 32'hA0A0_0001, 0); cycle();
        drive(0, 0, 0, 0, 1, 32'h4, 32'hB0B0_0002, 0); cycle();
        drive(0, 0, 0, 0, 1, 32'h8, 32'hC0C0_0003, 1); cycle();
        check("ld_done_st", {30'h0, state_o}, 32'h0);
        check("ld_done_pc", pc_o, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(i == 1, 0, 0, 0, 0, 0, 0, 0); cycle();
        end

        // Reset asserted mid-LOAD aborts asynchronously
        drive(0, 0, 0, 0, 1, 32'h20, 32'hDEAD_BEEF, 0); cycle();
        drive(0, 0, 0, 0, 1, 32'h20, 32'hDEAD_BEEF, 0); cycle();
        reset = 1'b0;
        #1;
        check("abort_state", {30'h0, state_o}, 32'h0);
        check("abort_gnt", {31'h0, ld_gnt_o}, 32'h0);
        check("abort_we", {31'h0, imem_we_o}, 32'h0);
        check("abort_pc", pc_o, 32'h0);
        m_state = 2'b00; m_pc = 32'h0; m_err = 1'b0;
        sb_q.delete();
        idle();
        @(negedge clock);
        reset = 1'b1;
        idle(); cycle(); check("post_rst_pc", pc_o, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sched.md
FETCH_SCHED -- requirements
Module: fetch_sched

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset and on loader completion.
REQ-002 Port: clock  input  1  single clock; all state updates on posedge clock.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 Port: stall_i  input  1  hazard stall request; freezes PC.
REQ-005 Port: redirect_i  input  1  branch/jump redirect valid.
REQ-006 Port: redirect_pc_i  input  32  redirect target.
REQ-007 Port: halt_i  input  1  halt request from core.
REQ-008 Port: ld_req_i  input  1  program-loader write request.
REQ-009 Port: ld_addr_i  input  32  loader write address.
REQ-010 Port: ld_data_i  input  32  loader write data.
REQ-011 Port: ld_last_i  input  1  marks final loader beat.
REQ-012 Port: imem_addr_o  output  32  instruction-memory address.
REQ-013 Port: imem_we_o  output  1  instruction-memory write enable.
REQ-014 Port: imem_wdata_o  output  32  instruction-memory write data.
REQ-015 Port: pc_o  output  32  current PC register.
REQ-016 Port: fetch_valid_o  output  1  instruction at imem_addr_o is a valid fetch this cycle.
REQ-017 Port: ld_gnt_o  output  1  loader owns instruction memory.
REQ-018 Port: redirect_err_o  output  1  one-cycle pulse on misaligned redirect.
REQ-019 Port: state_o  output  2  FSM state: RUN=2'b00, LOAD=2'b01, HALT=2'b10.

Function
REQ-020 FSM SHALL have states RUN, LOAD, HALT; encoding 2'b11 SHALL return to RUN with PC=RESET_PC next cycle.
REQ-021 RUN next state priority: ld_req_i -> LOAD; else halt_i -> HALT; else RUN.
REQ-022 LOAD: ld_req_i & ld_last_i -> RUN with PC=RESET_PC next cycle; otherwise stay LOAD.
REQ-023 HALT: ld_req_i -> LOAD; else aligned redirect_i -> RUN with PC=redirect_pc_i; else stay HALT.
REQ-024 RUN PC update priority: aligned redirect_i -> redirect_pc_i; else stall_i -> hold; else PC+4.
REQ-025 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 Redirect aligned iff redirect_pc_i[1:0]==2'b00; misaligned redirect in RUN or HALT SHALL be ignored and SHALL raise redirect_err_o for exactly the next cycle (registered).
REQ-027 redirect_i in RUN together with ld_req_i or halt_i: PC SHALL still take the aligned redirect target; state transition per REQ-021.
REQ-028 PC SHALL hold in LOAD (except completion per REQ-022) and in HALT (except exit per REQ-023).
REQ-029 imem_addr_o SHALL equal ld_addr_i in LOAD, pc_o otherwise (combinational mux).
REQ-030 ld_gnt_o SHALL be 1 iff state is LOAD (combinational from state).
REQ-031 imem_we_o SHALL equal ld_req_i & ld_gnt_o; imem_wdata_o SHALL equal ld_data_i in LOAD, 0 otherwise.
REQ-032 fetch_valid_o SHALL equal (state==RUN) & ~stall_i & ~ld_req_i; zero latency from inputs.
REQ-033 Loader request in RUN costs one transition cycle: first write occurs the cycle after ld_req_i is first seen; loader SHALL hold ld_req_i/ld_addr_i/ld_data_i until ld_gnt_o.
REQ-034 stall_i and halt_i SHALL be ignored in LOAD.

Reset
REQ-035 While reset==0: state=RUN, PC=RESET_PC, redirect_err_o=0, taking effect immediately without a clock edge.
REQ-036 Reset mid-LOAD SHALL abort the load; ld_gnt_o and imem_we_o SHALL drop to 0 asynchronously.
REQ-037 First posedge after reset release SHALL apply normal RUN rules (PC becomes RESET_PC+4 if no stall).

Verification
REQ-038 Reset release, 4 idle cycles -> pc_o 0,4,8,12,16; fetch_valid_o=1 throughout.
REQ-039 PC=8, stall_i=1 for 2 cycles, then redirect_i with target 32'h100 -> pc_o 8,8,32'h100,32'h104.
REQ-040 redirect_pc_i=32'h102 in RUN -> PC continues +4, redirect_err_o=1 exactly one cycle.
REQ-041 ld_req_i in RUN, 3 beats to 0x0/0x4/0x8, ld_last_i on the third -> state RUN->LOAD, imem_we_o=1 on 3 cycles with matching addr/data, then RUN with pc_o=RESET_PC.
REQ-042 halt_i in RUN -> HALT, pc_o frozen, fetch_valid_o=0; redirect to 32'h40 -> RUN, pc_o=32'h40.
REQ-043 PC=32'hFFFF_FFFC, no stall -> pc_o=0; reset asserted mid-LOAD -> state_o=RUN, ld_gnt_o=0, imem_we_o=0 before the next clock edge.
